// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core memory stage and a word-addressed
// data memory without byte enables. Sub-word stores use read-modify-write;
// loads return lane-extracted, sign- or zero-extended data.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; request fields latched on accept
// RD    | word read issued on the memory port
// MRG   | read data sampled: load extraction or sub-word merge
// WR    | single-cycle memory write strobe
// RESP  | one-cycle completion pulse, then back to IDLE
module lsu_mem_ctrl #(
    parameter int WIDTH1   = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [WIDTH1-1:0] req_addr,
    input  logic [WIDTH1-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WIDTH1-1:0] resp_rdata,
    output logic              resp_err,
    output logic [WIDTH1-1:0] mem_addr,
    output logic              mem_wr,
    output logic [WIDTH1-1:0] mem_wdata,
    input  logic [WIDTH1-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              req_err;
    logic              f3_bad;
    logic              misaligned;
    logic              out_of_range;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [WIDTH1-1:0] addr_q;
    logic [15:0]       lane_data_q;
    logic [WIDTH1-1:0] data_q;

    logic [WIDTH1-1:0] word_idx;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [WIDTH1-1:0] load_ext;
    logic [WIDTH1-1:0] merged;

    assign accept   = req_valid && (state == IDLE);
    assign word_idx = addr_q >> 2;

    // Reject decode on the live request so errors skip every memory access.
    always_comb begin
        if (req_we) begin
            f3_bad = (req_funct3 > 3'b010);
        end else begin
            f3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >> 2) >= WIDTH1'(MEM_SIZE);
        req_err      = f3_bad || misaligned || out_of_range;
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{(WIDTH1-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(WIDTH1-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(WIDTH1-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(WIDTH1-16){1'b0}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
        merged = mem_rdata;
        if (funct3_q[0]) begin
            merged[{addr_q[1], 4'b0000} +: 16] = lane_data_q;
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = lane_data_q[7:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and memory-port / handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt = RESP;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                mem_addr  = word_idx;
                state_nxt = MRG;
            end
            MRG: begin
                mem_addr  = word_idx;
                state_nxt = we_q ? WR : RESP;
            end
            WR: begin
                mem_addr  = word_idx;
                mem_wr    = 1'b1;
                mem_wdata = data_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, merge/extract registers and held response fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            lane_data_q <= '0;
            data_q      <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (accept) begin
                we_q        <= req_we;
                funct3_q    <= req_funct3;
                addr_q      <= req_addr;
                lane_data_q <= req_wdata[15:0];
                data_q      <= req_wdata;
                if (req_err) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
            if (state == MRG) begin
                if (we_q) begin
                    data_q <= merged;
                end else begin
                    resp_rdata <= load_ext;
                    resp_err   <= 1'b0;
                end
            end
            if (state == WR) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the core's memory-stage request interface and the word-addressed data memory.
- Accepts one byte-addressed RV32I load/store at a time via a valid/ready handshake and converts it to word-index accesses on the memory port.
- The memory has no byte enables, so sub-word stores (SB/SH) use a read-modify-write sequence.
- Performs load byte-lane extraction with sign or zero extension, and flags misaligned, out-of-range or illegal requests.

Parameters:
- WIDTH1, 32, data and address width.
- MEM_SIZE, 1024, memory depth in words; valid word index is 0..MEM_SIZE-1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  WIDTH1  byte address.
- req_wdata  in  WIDTH1  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WIDTH1  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; no memory write occurred.
- mem_addr  out  WIDTH1  word index (req_addr >> 2).
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  WIDTH1  memory write data.
- mem_rdata  in  WIDTH1  memory read data. Valid the cycle after mem_addr is driven with mem_wr=0.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; req_ready=1;
  - resp_valid=0, resp_rdata=0, resp_err=0;
  - mem_wr=0, mem_addr=0, mem_wdata=0.
- States: IDLE, RD, MRG, WR, RESP.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready at a posedge; all request fields are latched at that edge.
- Error check at accept. Any of the following sends the request directly to RESP with resp_err=1 and no memory access:
  - illegal funct3 (loads 011/110/111; stores other than 000–010);
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= MEM_SIZE.
- State sequences after acceptance (cycle 0 = accept cycle):
  - Error: RESP (cycle 1).
  - SW: WR (cycle 1), RESP (cycle 2).
  - Loads: RD (1), MRG (2), RESP (3).
  - SB/SH: RD (1), MRG (2), WR (3), RESP (4).
- RD: mem_addr = latched word index, mem_wr=0.
- MRG: mem_rdata is sampled this cycle.
  - Loads: extract, extend and register into the response.
  - SB/SH: register merged word = mem_rdata with the selected lane replaced.
- WR: mem_wr=1 for exactly one cycle; mem_addr = word index.
  - mem_wdata = req_wdata for SW, or the merged word for SB/SH.
- mem_wr=0 in every other state. mem_addr=0 in IDLE and RESP.
- Lane rules:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]];
  - LB/LH sign-extend; LBU/LHU zero-extend;
  - SB/SH insert req_wdata[7:0] / req_wdata[15:0]; all other bytes are preserved.
- RESP: resp_valid=1 for one cycle; next state is IDLE.
  - The response is not back-pressured.
  - resp_rdata and resp_err hold their value until the next RESP.
  - A new request can be accepted the cycle after RESP.
- req_valid while busy: ignored (req_ready=0). The requester must hold its request.
- Reset mid-operation: abort immediately.
  - A pending SB/SH whose WR state has not been reached never writes.
  - A WR cycle cut short by reset deasserts mem_wr asynchronously.
- Memory reads issued while mem_wr=0 in other states are harmless. Their data is only consumed in MRG.

Test Plan:
- Initialise word 4 = 0x8877_6655. LW addr 0x10 → resp at cycle 3, resp_rdata=0x8877_6655, resp_err=0. LB 0x13 → 0xFFFF_FF88. LBU 0x13 → 0x0000_0088. LH 0x12 → 0xFFFF_8877. LHU 0x10 → 0x0000_6655.
- SW 0xDEAD_BEEF to 0x20 → mem_wr high one cycle at cycle 1, mem_addr=8; resp at cycle 2. LW 0x20 returns 0xDEAD_BEEF.
- Word 8 = 0xDEAD_BEEF. SB 0x0000_0012 to 0x21 → word 8 becomes 0xDEAD_12EF. SH 0x0000_ABCD to 0x22 → word 8 becomes 0xABCD_12EF. Each store responds at cycle 4; mem_wr pulses once.
- Misaligned LW 0x11, SH 0x23, out-of-range LW 0x1000 (index 1024), LD funct3=011 → resp_err=1 at cycle 1, resp_rdata=0, mem_wr never asserted.
- req_valid held high continuously with back-to-back requests → req_ready low from cycle 1 until the cycle after RESP; each request completes exactly once, in order.
- Assert reset during an SB's MRG state → mem_wr stays 0, target word unchanged, outputs at reset values, req_ready=1 once reset is released.
